// File: rtl/key_mode_sched_if.sv
// Key/LED bundle between the board pins and the mode scheduler.
// master: the scheduler (samples key, drives mode/led/strobes).
// slave: the board side or testbench (drives key, observes the rest).
interface key_mode_sched_if;
  logic       key;
  logic [1:0] mode;
  logic       led;
  logic       short_pulse;
  logic       long_pulse;

  modport master (
    input  key,
    output mode,
    output led,
    output short_pulse,
    output long_pulse
  );

  modport slave (
    output key,
    input  mode,
    input  led,
    input  short_pulse,
    input  long_pulse
  );
endinterface

// File: rtl/key_mode_sched.sv
// Purpose: debounce one push-button, classify short/long presses, step a 4-state LED mode and blink the LED.
// Latency: key_db follows key 2+DEBOUNCE_CYC cycles later; strobes combinational from state; mode/led update 1 cycle after a strobe.
// Backpressure: none; strobes are single-cycle and unconditionally accepted. Optional auto-repeat: KEY_AUTO_REPEAT_EN.
module key_mode_sched #(
  parameter int DEBOUNCE_CYC = 270000,
  parameter int LONG_CYC     = 27000000,
  parameter int BLINK_CYC    = 6750000
`ifdef KEY_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_CYC   = 13500000
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  key_mode_sched_if.master  bus
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYC) + 1;
  localparam int HOLD_W = $clog2(LONG_CYC) + 1;
  localparam int BL_W   = $clog2(BLINK_CYC) + 1;

  localparam logic [DB_W-1:0]   DB_LIM   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(LONG_CYC - 1);
  localparam logic [BL_W-1:0]   SLOW_LIM = BL_W'(BLINK_CYC - 1);
  localparam logic [BL_W-1:0]   FAST_LIM = BL_W'(BLINK_CYC / 4 - 1);

`ifdef KEY_AUTO_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYC) + 1;
  localparam logic [REP_W-1:0] REP_LIM = REP_W'(REPEAT_CYC - 1);
`endif

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } state_t;

  logic              key_s1_q, key_s1_d;
  logic              key_s_q, key_s_d;
  logic              key_db_q, key_db_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic              led_q, led_d;
  logic [BL_W-1:0]   bl_cnt_q, bl_cnt_d;
  logic              short_pulse;
  logic              long_pulse;
`ifdef KEY_AUTO_REPEAT_EN
  logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
`endif

  // Two-flop synchroniser for the asynchronous key pin.
  always_comb begin
    key_s1_d = bus.key;
    key_s_d  = key_s1_q;
  end

  // Debounce: accept a new level only after it has been stable for DEBOUNCE_CYC cycles.
  always_comb begin
    key_db_d = key_db_q;
    db_cnt_d = '0;
    if (key_s_q != key_db_q) begin
      if (db_cnt_q == DB_LIM) begin
        key_db_d = key_s_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // Press classifier: short strobe on early release, long strobe at the hold limit.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    short_pulse = 1'b0;
    long_pulse  = 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
    rep_cnt_d   = '0;
`endif
    case (state_q)
      IDLE: begin
        // key_db can only be high here on a fresh rising edge: every path back to IDLE requires key_db low.
        if (key_db_q) begin
          state_d    = PRESSED;
          hold_cnt_d = '0;
        end
      end
      PRESSED: begin
        if (!key_db_q) begin
          short_pulse = 1'b1;
          state_d     = IDLE;
        end else if (hold_cnt_q == HOLD_LIM) begin
          long_pulse = 1'b1;
          state_d    = LONG_HELD;
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      LONG_HELD: begin
        if (!key_db_q) begin
          state_d = IDLE;
`ifdef KEY_AUTO_REPEAT_EN
        end else if (rep_cnt_q == REP_LIM) begin
          short_pulse = 1'b1;
          rep_cnt_d   = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + REP_W'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Mode sequencing and LED pattern; any mode change restarts the blink phase lit.
  always_comb begin
    mode_d   = mode_q;
    led_d    = led_q;
    bl_cnt_d = bl_cnt_q;
    if (long_pulse) begin
      mode_d = 2'd0;
    end else if (short_pulse) begin
      mode_d = mode_q + 2'd1;
    end

    if (mode_d != mode_q) begin
      bl_cnt_d = '0;
      led_d    = (mode_d != 2'd0);
    end else begin
      case (mode_q)
        2'd0: begin
          led_d    = 1'b0;
          bl_cnt_d = '0;
        end
        2'd1: begin
          led_d    = 1'b1;
          bl_cnt_d = '0;
        end
        2'd2: begin
          if (bl_cnt_q == SLOW_LIM) begin
            led_d    = ~led_q;
            bl_cnt_d = '0;
          end else begin
            bl_cnt_d = bl_cnt_q + BL_W'(1);
          end
        end
        default: begin
          if (bl_cnt_q == FAST_LIM) begin
            led_d    = ~led_q;
            bl_cnt_d = '0;
          end else begin
            bl_cnt_d = bl_cnt_q + BL_W'(1);
          end
        end
      endcase
    end
  end

  // State register; reset clears everything at once, including mid-press and mid-blink.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1_q   <= 1'b0;
      key_s_q    <= 1'b0;
      key_db_q   <= 1'b0;
      db_cnt_q   <= '0;
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      mode_q     <= 2'd0;
      led_q      <= 1'b0;
      bl_cnt_q   <= '0;
`ifdef KEY_AUTO_REPEAT_EN
      rep_cnt_q  <= '0;
`endif
    end else begin
      key_s1_q   <= key_s1_d;
      key_s_q    <= key_s_d;
      key_db_q   <= key_db_d;
      db_cnt_q   <= db_cnt_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      mode_q     <= mode_d;
      led_q      <= led_d;
      bl_cnt_q   <= bl_cnt_d;
`ifdef KEY_AUTO_REPEAT_EN
      rep_cnt_q  <= rep_cnt_d;
`endif
    end
  end

  assign bus.mode        = mode_q;
  assign bus.led         = led_q;
  assign bus.short_pulse = short_pulse;
  assign bus.long_pulse  = long_pulse;

endmodule
